// File: rtl/fifo_push_arb.sv
// fifo_push_arb
//   Arbitrates NUM_REQ producers onto a single FIFO push port. Priority starts
//   at ptr and searches upward (mod NUM_REQ). The current winner keeps priority
//   for up to MAX_BURST consecutive transfers, after which priority is forced
//   to the next producer. Grant, push and write data are combinational, so a
//   winning producer transfers in the same cycle it requests.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-producer request, held with its data until granted
//   req_data   producer i data on [i*DATA_W +: DATA_W]
//   gnt        one-hot grant (all-zero in reset, when full, or with no request)
//   full       FIFO full flag
//   push       FIFO write enable, OR of (req & gnt)
//   d_in       FIFO write data, granted producer's data or zero
//   stall_cnt  saturating count of cycles with a request pending while full
module fifo_push_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      full,
    output logic                      push,
    output logic [DATA_W-1:0]         d_in,
    output logic [15:0]               stall_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] last;
    logic [3:0]       burst_cnt;

    logic [PTR_W-1:0] win;
    logic             found;
    logic [3:0]       burst_nxt;

    // Advance an index by one, wrapping at NUM_REQ (which need not be a power of two).
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1)
            return '0;
        else
            return idx + PTR_W'(1);
    endfunction

    // Saturating increment for the 16-bit stall counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Rotating priority search: first asserted request at or after ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (found && !rst && !full)
            gnt = NUM_REQ'(1) << win;
    end

    assign push = |(req & gnt);

    // gnt is never set without its req, so a zero gnt also forces d_in to zero.
    always_comb begin
        d_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i])
                d_in = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Burst length including the transfer happening this cycle.
    assign burst_nxt = (win == last) ? burst_cnt + 4'd1 : 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            last      <= '0;
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (full && |req)
                stall_cnt <= sat_inc16(stall_cnt);

            // While full, arbitration state is frozen so the owner is not
            // penalised for back-pressure.
            if (!full) begin
                if (push) begin
                    last <= win;
                    if (burst_nxt == 4'(MAX_BURST)) begin
                        ptr       <= wrap_inc(win);
                        burst_cnt <= '0;
                    end else begin
                        ptr       <= win;
                        burst_cnt <= burst_nxt;
                    end
                end else begin
                    // Idle cycle: release ownership to the producer after the last winner.
                    ptr       <= wrap_inc(last);
                    burst_cnt <= '0;
                end
            end
        end
    end

endmodule
